// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard control unit for a five-stage in-order pipeline. It resolves three
// hazard sources and drives stall and flush controls for the stage registers:
//   - data-memory wait (M-stage access not yet acknowledged)
//   - taken branch / jump resolved in E
//   - load-use dependency between the load in E and the sources in D
// A memory access that stays unacknowledged for TIMEOUT consecutive cycles
// locks the unit into an error state. Only reset leaves that state.
// The unit also keeps a saturating count of cycles with any stall asserted.
//
// Parameters
//   TIMEOUT      maximum consecutive data-memory wait cycles before error
//   CNT_W        width of the stall-cycle performance counter
//
// Ports
//   clk          pipeline clock; all state changes on the rising edge
//   rst          asynchronous active-low reset
//   MemReadE     instruction in E is a load
//   RD_E         destination register of the instruction in E
//   Rs1_D        first source register of the instruction in D
//   Rs2_D        second source register of the instruction in D
//   PCSrcE       branch/jump taken, resolved in E
//   dmem_req_M   M-stage data-memory access is valid
//   dmem_ready   data-memory acknowledge
//   StallF       hold the F stage register (PC)
//   StallD       hold the D stage register
//   StallE       hold the E stage register
//   StallM       hold the M stage register
//   FlushD       insert a bubble into the D stage register
//   FlushE       insert a bubble into the E stage register
//   FlushW       insert a bubble into the W stage register
//   mem_err      sticky memory-timeout flag
//   stall_cycles saturating count of cycles with any stall asserted
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             PCSrcE,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // The wait counter only ever holds 0 .. TIMEOUT-1 before the error state
    // is taken, so ceil(log2(TIMEOUT)) bits are enough.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              mem_hold;
    logic              load_use;
    logic              any_stall;

    // Hazard detection. A memory hold is meaningless once the unit has
    // locked up, so it is masked in ERR. A load writing x0 never creates a
    // real dependency, hence the RD_E != 0 term.
    always_comb begin
        mem_hold = (state != ERR) & dmem_req_M & ~dmem_ready;
        load_use = MemReadE & (RD_E != 5'd0) &
                   ((RD_E == Rs1_D) | (RD_E == Rs2_D));
    end

    // Stall/flush generation in strict priority order:
    // ERR > memory hold > taken branch > load-use.
    // While memory holds, the whole front of the pipe freezes and W takes a
    // bubble. A branch seen during the hold is still sitting in the held E
    // register, so it is acted on in the release cycle. During reset every
    // control is forced low, whatever the inputs are doing.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            StallF = 1'b0;
        end else if ((state == ERR) || mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
        any_stall = StallF | StallD | StallE | StallM;
    end

    // Next-state logic. The wait counter counts consecutive hold cycles
    // starting with the first hold seen in RUN. When the hold that would be
    // number TIMEOUT arrives, the unit moves to ERR. Releasing the hold
    // drops straight back to RUN in the same cycle, so a memory wait adds
    // no latency beyond the hold cycles themselves.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_hold) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_next    = ERR;
                        wait_cnt_next = '0;
                    end else begin
                        state_next    = MEM_WAIT;
                        wait_cnt_next = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            ERR: begin
                state_next    = ERR;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // State, wait counter, sticky error flag and performance counter.
    // The error flag is set on the edge that enters ERR, so it rises
    // together with the state. The stall counter stops at all-ones
    // instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == ERR) begin
                mem_err <= 1'b1;
            end
            if (any_stall && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl, built with TIMEOUT=4 and
// CNT_W=4 so that the timeout and saturation corners are reached quickly.
// A directed vector table walks the main scenarios. A hand-written sequence
// drives the counter into saturation. A randomized phase is then checked
// against a behavioural model that works from hold counts and plain
// integers. Inputs change 1 time unit after the rising edge, and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rstN;
    logic             memReadE;
    logic [4:0]       rdE;
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic             pcSrcE;
    logic             dmemReqM;
    logic             dmemReady;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             memErr;
    logic [CNT_W-1:0] stallCycles;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state: consecutive hold count, lock-up flag, stall count
    int modelHolds = 0;
    bit modelErr   = 1'b0;
    int modelCnt   = 0;

    typedef struct {
        logic       rstN;
        logic       memRead;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       pc;
        logic       req;
        logic       ready;
        logic [7:0] expFlags;
        logic [3:0] expCnt;
    } vec_t;

    vec_t vecQ[$];

    pipeline_hazard_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rstN),
        .MemReadE    (memReadE),
        .RD_E        (rdE),
        .Rs1_D       (rs1D),
        .Rs2_D       (rs2D),
        .PCSrcE      (pcSrcE),
        .dmem_req_M  (dmemReqM),
        .dmem_ready  (dmemReady),
        .StallF      (stallF),
        .StallD      (stallD),
        .StallE      (stallE),
        .StallM      (stallM),
        .FlushD      (flushD),
        .FlushE      (flushE),
        .FlushW      (flushW),
        .mem_err     (memErr),
        .stall_cycles(stallCycles)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Drive one set of DUT inputs
    task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic pc, input logic req, input logic ready);
        rstN      = r;
        memReadE  = mr;
        rdE       = rd;
        rs1D      = rs1;
        rs2D      = rs2;
        pcSrcE    = pc;
        dmemReqM  = req;
        dmemReady = ready;
    endtask

    // Compare the control flags and the stall counter with the expected values
    // Flag order: StallF StallD StallE StallM FlushD FlushE FlushW mem_err
    task automatic checkOutput(input string name, input logic [7:0] expFlags,
                               input logic [CNT_W-1:0] expCnt);
        logic [7:0] act;
        act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr};
        compared++;
        if (act !== expFlags) begin
            mismatched++;
            $display("[TB] FAIL %s flags: got %b, expected %b (t=%0t)", name, act, expFlags, $time);
        end
        compared++;
        if (stallCycles !== expCnt) begin
            mismatched++;
            $display("[TB] FAIL %s stall_cycles: got %0d, expected %0d (t=%0t)", name, stallCycles, expCnt, $time);
        end
    endtask

    // Expected flags from the current inputs and the model state
    function automatic logic [7:0] modelFlags();
        logic hold;
        logic loadUse;
        hold    = dmemReqM && !dmemReady;
        loadUse = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
        if (!rstN)                 return 8'b0000_0000;
        else if (modelErr)         return 8'b1111_0011;
        else if (hold)             return 8'b1111_0010;
        else if (pcSrcE)           return 8'b0000_1100;
        else if (loadUse)          return 8'b1100_0100;
        else                       return 8'b0000_0000;
    endfunction

    function automatic logic [CNT_W-1:0] modelCount();
        return rstN ? CNT_W'(modelCnt) : '0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelAdvance();
        logic [7:0] f;
        if (!rstN) begin
            modelHolds = 0;
            modelErr   = 1'b0;
            modelCnt   = 0;
        end else begin
            f = modelFlags();
            if (|f[7:4]) modelCnt = (modelCnt + 1 > CNT_MAX) ? CNT_MAX : modelCnt + 1;
            if (!modelErr) begin
                if (dmemReqM && !dmemReady) begin
                    modelHolds++;
                    if (modelHolds >= TIMEOUT) modelErr = 1'b1;
                end else begin
                    modelHolds = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic addVec(input logic r, input logic mr, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic pc,
                          input logic req, input logic ready,
                          input logic [7:0] ef, input logic [3:0] ec);
        vec_t v;
        v.rstN = r; v.memRead = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.pc = pc; v.req = req; v.ready = ready; v.expFlags = ef; v.expCnt = ec;
        vecQ.push_back(v);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Directed table:  rst mr rd rs1 rs2 pc req rdy  flags  cnt
        addVec(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);   // reset dominates hold inputs
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);   // idle
        addVec(1, 1, 5, 0, 5, 0, 0, 0, 8'hC4, 0);   // load-use on Rs2
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1);   // one cycle only, counted once
        addVec(1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1);   // RD_E = 0 never stalls
        addVec(1, 1, 3, 3, 0, 1, 0, 0, 8'h0C, 1);   // branch beats load-use
        addVec(1, 1, 7, 6, 8, 0, 0, 0, 8'h00, 1);   // load without dependency
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 1);   // memory wait, 3 cycles
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 2);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 3);
        addVec(1, 0, 0, 0, 0, 0, 1, 1, 8'h00, 4);   // release, no extra latency
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 4);
        addVec(1, 0, 0, 0, 0, 1, 1, 0, 8'hF2, 4);   // branch held behind memory
        addVec(1, 1, 2, 2, 0, 1, 1, 0, 8'hF2, 5);
        addVec(1, 0, 0, 0, 0, 1, 1, 1, 8'h0C, 6);   // branch acts on release
        addVec(1, 1, 4, 0, 4, 0, 0, 0, 8'hC4, 6);   // no request, no hold
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 7);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 7);   // four holds -> timeout
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 8);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 9);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 10);
        addVec(1, 0, 0, 0, 0, 0, 1, 1, 8'hF3, 11);  // ERR ignores ready
        addVec(1, 1, 1, 1, 1, 1, 0, 0, 8'hF3, 12);  // ERR beats branch
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'hF3, 13);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'hF3, 14);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'hF3, 15);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'hF3, 15);  // counter saturated
        addVec(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);   // reset leaves ERR
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 0);   // hold, then reset mid-wait
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 1);
        addVec(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        addVec(1, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0);   // first cycle evaluates as RUN
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 0);   // wait counter restarted from 0
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 1);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 2);
        addVec(1, 0, 0, 0, 0, 0, 1, 0, 8'hF2, 3);
        addVec(1, 0, 0, 0, 0, 0, 1, 1, 8'hF3, 4);   // ERR only after the 4th hold

        foreach (vecQ[i]) begin
            applyStimulus(vecQ[i].rstN, vecQ[i].memRead, vecQ[i].rd, vecQ[i].rs1,
                          vecQ[i].rs2, vecQ[i].pc, vecQ[i].req, vecQ[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecQ[i].expFlags, vecQ[i].expCnt);
            tick();
        end

        // Saturation: 20 back-to-back load-use stalls after a fresh reset
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("sat%0d", k), 8'hC4, CNT_W'((k > CNT_MAX) ? CNT_MAX : k));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sat_final", 8'h00, 4'd15);
        tick();

        // Randomized phase against the behavioural model
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            logic slowMem;
            slowMem = ((n / 64) % 2) == 1;
            applyStimulus($urandom_range(0, 99) != 0,
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0,
                          1'($urandom_range(0, 1)),
                          slowMem ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
            @(negedge clk);
            checkOutput($sformatf("rand%0d", n), modelFlags(), modelCount());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
